alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec_pkg.sv | 32 +++
 rtl/alu_exec_regfile.sv | 44 ++++
 rtl/alu_exec.sv | 161 ++++++++++++++++
 tb/tb_alu_exec.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_exec_pkg : shared types and encodings for the ALU exec slice |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
package alu_exec_pkg;

  localparam int c_data_w = 8;
  localparam int c_addr_w = 2;

  typedef logic [c_data_w-1:0] data_t;
  typedef logic [c_addr_w-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    NOT = 3'b101,
    SHL = 3'b110,
    SHR = 3'b111
  } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/alu_exec_regfile.sv
`default_nettype none
// +------------------------------------------------------------------+
// | exec_regfile : 1W / 2R general registers plus a debug read port  |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
module exec_regfile
  import alu_exec_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_we,
  input  reg_addr_t i_waddr,
  input  data_t     i_wdata,
  input  reg_addr_t i_raddr_a,
  output data_t     o_rdata_a,
  input  reg_addr_t i_raddr_b,
  output data_t     o_rdata_b,
  input  reg_addr_t i_dbg_addr,
  output data_t     o_dbg_data
);

  data_t r_regs [NREGS];

  generate
    for (genvar g = 0; g < NREGS; g++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_regs[g] <= '0;
        end else if (i_we && (i_waddr == reg_addr_t'(g))) begin
          r_regs[g] <= i_wdata;
        end
      end
    end
  endgenerate

  // Addresses beyond the populated registers read as zero.
  assign o_rdata_a  = (int'(i_raddr_a)  < NREGS) ? r_regs[i_raddr_a]  : '0;
  assign o_rdata_b  = (int'(i_raddr_b)  < NREGS) ? r_regs[i_raddr_b]  : '0;
  assign o_dbg_data = (int'(i_dbg_addr) < NREGS) ? r_regs[i_dbg_addr] : '0;

endmodule
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_exec : sequences one instruction through an external ALU     |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [1:0] in_rd,
  input  logic [1:0] in_ra,
  input  logic [1:0] in_rb,
  input  logic       in_imm_sel,
  input  logic [7:0] in_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_s,
  input  logic [7:0] alu_out,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_c,
  input  logic       alu_v,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [1:0] res_rd,
  output logic [3:0] flags,
  output logic [7:0] icount,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data
);

  state_t    r_state;
  state_t    w_next;
  alu_op_t   r_op;
  reg_addr_t r_rd;
  reg_addr_t r_ra;
  reg_addr_t r_rb;
  logic      r_imm_sel;
  data_t     r_imm;
  data_t     r_res_data;
  reg_addr_t r_res_rd;
  logic [3:0] r_flags;
  logic [7:0] r_icount;

  logic  w_idle_ready;
  logic  w_in_hs;
  logic  w_wb;
  logic  w_res_hs;
  logic  w_drive_alu;
  data_t w_rdata_a;
  data_t w_rdata_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_idle_ready = 1'b0;
    w_drive_alu  = 1'b0;
    w_wb         = 1'b0;
    res_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        w_idle_ready = 1'b1;
        if (in_valid) w_next = EXEC;
      end
      EXEC: begin
        w_drive_alu = 1'b1;
        w_wb        = 1'b1;
        w_next      = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Reset forces IDLE asynchronously; mask ready so nothing is offered while held.
  assign in_ready = w_idle_ready & ~rst;
  assign w_in_hs  = in_valid & in_ready;
  assign w_res_hs = res_valid & res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= ADD;
      r_rd      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_imm_sel <= 1'b0;
      r_imm     <= '0;
    end else if (w_in_hs) begin
      r_op      <= alu_op_t'(in_op);
      r_rd      <= in_rd;
      r_ra      <= in_ra;
      r_rb      <= in_rb;
      r_imm_sel <= in_imm_sel;
      r_imm     <= in_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_data <= '0;
      r_res_rd   <= '0;
      r_flags    <= '0;
    end else if (w_wb) begin
      r_res_data <= alu_out;
      r_res_rd   <= r_rd;
      r_flags    <= {alu_z, alu_n, alu_c, alu_v};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_icount <= '0;
    end else if (w_res_hs) begin
      r_icount <= r_icount + 8'd1;
    end
  end

  exec_regfile #(
    .NREGS(NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_wb),
    .i_waddr   (r_rd),
    .i_wdata   (alu_out),
    .i_raddr_a (r_ra),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (r_rb),
    .o_rdata_b (w_rdata_b),
    .i_dbg_addr(dbg_addr),
    .o_dbg_data(dbg_data)
  );

  assign alu_a = w_drive_alu ? w_rdata_a : '0;
  assign alu_b = w_drive_alu ? (r_imm_sel ? r_imm : w_rdata_b) : '0;
  assign alu_s = w_drive_alu ? r_op : 3'b000;

  assign res_data = r_res_data;
  assign res_rd   = r_res_rd;
  assign flags    = r_flags;
  assign icount   = r_icount;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_exec : directed scoreboard bench for alu_exec             |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module tb_alu_exec;
  import alu_exec_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [1:0] in_rd, in_ra, in_rb;
  logic       in_imm_sel;
  logic [7:0] in_imm;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_s;
  logic [7:0] alu_out;
  logic       alu_z, alu_n, alu_c, alu_v;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_rd;
  logic [3:0] flags;
  logic [7:0] icount;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  alu_exec #(.NREGS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
    .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd), .flags(flags), .icount(icount),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // External ALU stand-in: c is carry for ADD, borrow for SUB, shifted-out bit for shifts.
  logic [8:0] w_sum;
  always_comb begin
    w_sum   = '0;
    alu_out = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op_t'(alu_s))
      ADD: begin
        w_sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = w_sum[7:0];
        alu_c   = w_sum[8];
        alu_v   = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
      end
      SUB: begin
        alu_out = alu_a - alu_b;
        alu_c   = alu_a < alu_b;
        alu_v   = (alu_a[7] != alu_b[7]) && (alu_out[7] != alu_a[7]);
      end
      AND: alu_out = alu_a & alu_b;
      OR:  alu_out = alu_a | alu_b;
      XOR: alu_out = alu_a ^ alu_b;
      NOT: alu_out = ~alu_a;
      SHL: begin alu_out = {alu_a[6:0], 1'b0}; alu_c = alu_a[7]; end
      SHR: begin alu_out = {1'b0, alu_a[7:1]}; alu_c = alu_a[0]; end
      default: alu_out = '0;
    endcase
    alu_z = (alu_out == 8'h00);
    alu_n = alu_out[7];
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] rd;
    logic [3:0] flg;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] exp_regs [4];
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every accepted result is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got data %0h rd %0d with empty scoreboard", res_data, res_rd);
        end else begin
          e = sb_q.pop_front();
          chk("res_data", 32'(res_data), 32'(e.data));
          chk("res_rd", 32'(res_rd), 32'(e.rd));
          chk("flags", 32'(flags), 32'(e.flg));
        end
      end
    end
  end

  task automatic check_regs_zero(input string name);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk(name, 32'(dbg_data), 32'h0);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic isel, input logic [7:0] imm,
                       input logic [7:0] exp_d, input logic [3:0] exp_f, input bit wait_idle);
    int k;
    @(negedge clk);
    in_op = op; in_rd = rd; in_ra = ra; in_rb = rb; in_imm_sel = isel; in_imm = imm;
    in_valid = 1'b1;
    dbg_addr = rd;
    k = 0;
    while (!in_ready && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'h1);
      in_valid = 1'b0;
      return;
    end
    sb_q.push_back('{data: exp_d, rd: rd, flg: exp_f});
    @(posedge clk);
    #1;
    // Scramble the inputs so only latched fields can produce the right answer.
    in_valid = 1'b0; in_op = ~op; in_ra = ~ra; in_rb = ~rb; in_imm = ~imm; in_imm_sel = ~isel;
    @(negedge clk);
    chk("exec_in_ready", 32'(in_ready), 32'h0);
    chk("exec_res_valid", 32'(res_valid), 32'h0);
    chk("exec_alu_a", 32'(alu_a), 32'(exp_regs[ra]));
    chk("exec_alu_b", 32'(alu_b), 32'(isel ? imm : exp_regs[rb]));
    chk("exec_alu_s", 32'(alu_s), 32'(op));
    chk("exec_dbg_prewrite", 32'(dbg_data), 32'(exp_regs[rd]));
    @(negedge clk);
    chk("done_res_valid", 32'(res_valid), 32'h1);
    chk("done_in_ready", 32'(in_ready), 32'h0);
    chk("done_alu_zero", 32'({alu_a, alu_b, alu_s}), 32'h0);
    chk("done_dbg_written", 32'(dbg_data), 32'(exp_d));
    exp_regs[rd] = exp_d;
    if (wait_idle) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!in_ready && k < 8);
      chk("return_idle", 32'(in_ready), 32'h1);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] held;
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b1;
    in_op = '0; in_rd = '0; in_ra = '0; in_rb = '0; in_imm_sel = 1'b0; in_imm = '0;
    dbg_addr = '0;
    for (int i = 0; i < 4; i++) exp_regs[i] = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_alu_zero", 32'({alu_a, alu_b, alu_s}), 32'h0);
    chk("rst_state", 32'({res_data, res_rd, flags, icount}), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    check_regs_zero("rst_regs");

    issue(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 8'h05, 4'b0000, 1'b1);
    issue(SUB, 2'd2, 2'd1, 2'd0, 1'b1, 8'h05, 8'h00, 4'b1000, 1'b1);
    issue(ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'hC0, 8'hC0, 4'b0100, 1'b1);
    issue(SHL, 2'd3, 2'd3, 2'd0, 1'b0, 8'h00, 8'h80, 4'b0110, 1'b1);
    issue(SHL, 2'd3, 2'd3, 2'd0, 1'b0, 8'h00, 8'h00, 4'b1010, 1'b1);
    issue(ADD, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 8'h0A, 4'b0000, 1'b1);
    issue(OR,  2'd0, 2'd1, 2'd0, 1'b1, 8'hF0, 8'hFA, 4'b0100, 1'b1);
    issue(SUB, 2'd2, 2'd1, 2'd0, 1'b0, 8'h00, 8'h10, 4'b0010, 1'b1);
    chk("icount_after_8", 32'(icount), 32'd8);

    // Backpressure: result must hold while fresh requests are ignored.
    res_ready = 1'b0;
    issue(ADD, 2'd2, 2'd2, 2'd0, 1'b1, 8'h01, 8'h11, 4'b0000, 1'b0);
    held = res_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k % 2 == 0); in_op = ADD; in_rd = 2'd0; in_ra = 2'd0; in_imm_sel = 1'b1; in_imm = 8'h55;
      chk("bp_res_valid", 32'(res_valid), 32'h1);
      chk("bp_res_data", 32'(res_data), 32'(held));
      chk("bp_res_data_value", 32'(res_data), 32'h11);
      chk("bp_res_rd", 32'(res_rd), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_icount", 32'(icount), 32'd8);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_icount_release", 32'(icount), 32'd9);
    chk("bp_idle_res_valid", 32'(res_valid), 32'h0);
    chk("bp_idle_in_ready", 32'(in_ready), 32'h1);
    dbg_addr = 2'd0;
    #1 chk("bp_no_extra_write", 32'(dbg_data), 32'hFA);
    @(negedge clk);
    chk("bp_no_extra_result", 32'(res_valid), 32'h0);

    // Abort: reset lands while the instruction is in EXEC.
    @(negedge clk);
    in_op = ADD; in_rd = 2'd1; in_ra = 2'd0; in_imm_sel = 1'b1; in_imm = 8'h7F; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("abort_exec_alu_b", 32'(alu_b), 32'h7F);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rst_in_ready", 32'(in_ready), 32'h0);
    chk("abort_rst_alu_zero", 32'({alu_a, alu_b, alu_s}), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'h1);
    chk("abort_icount", 32'(icount), 32'h0);
    chk("abort_res_valid", 32'(res_valid), 32'h0);
    chk("abort_flags", 32'(flags), 32'h0);
    check_regs_zero("abort_regs");
    for (int i = 0; i < 4; i++) exp_regs[i] = 8'h00;

    // Wrap: reg0 counts up by one per instruction alongside icount.
    for (int i = 0; i < 256; i++) begin
      d = 8'(i + 1);
      issue(ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01, d,
            {d == 8'h00, d[7], i == 255, i == 127}, 1'b1);
      if (i == 254) chk("icount_ff", 32'(icount), 32'hFF);
    end
    chk("icount_wrap", 32'(icount), 32'h00);
    @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
